// File: rtl/ro_scan_controller.sv
// Ring-oscillator scan sequencer: runs one RO at a time, settles, counts synchronized
// rising edges over a captured window, reports the count, then moves to the next RO.
module ro_scan_controller #(
  parameter int  NUM_RO     = 4,
  parameter int  CNT_W      = 16,
  parameter int  WIN_W      = 16,
  parameter int  SETTLE_CYC = 8,
  localparam int IDX_W      = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  output logic              done
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RO - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, REPORT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WIN_W-1:0]   win_q, win_d;       // last MEASURE cycle index (window - 1)
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_sat_q, res_sat_d;
  logic               edge_det;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    res_idx_d   = res_idx_q;
    res_count_d = res_count_q;
    res_sat_d   = res_sat_q;
    s1_d        = ro_out[idx_q];
    s2_d        = s1_q;
    s3_d        = s2_q;
    edge_det    = s2_q & ~s3_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            win_d   = (window_len == '0) ? '0 : window_len - WIN_W'(1);
            idx_d   = '0;
            tmr_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          // Synchronizer is flushing the previous RO's samples; edges are discarded.
          cnt_d = '0;
          sat_d = 1'b0;
          if (tmr_q == SET_LAST) begin
            tmr_d   = '0;
            state_d = MEASURE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        MEASURE: begin
          if (edge_det) begin
            if (&cnt_q) sat_d = 1'b1;   // an edge was lost to saturation
            else        cnt_d = cnt_q + CNT_W'(1);
          end
          if (tmr_q == TMR_W'(win_q)) begin
            res_idx_d   = idx_q;
            res_count_d = cnt_d;
            res_sat_d   = sat_d;
            state_d     = REPORT;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        REPORT: begin
          if (idx_q == IDX_LAST) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tmr_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = SETTLE;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      res_idx_q   <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      res_idx_q   <= res_idx_d;
      res_count_q <= res_count_d;
      res_sat_q   <= res_sat_d;
    end
  end

  // Enables decode straight from state flops so an async reset kills them at once.
  always_comb begin
    ro_en = '0;
    if ((state_q == SETTLE) || (state_q == MEASURE)) ro_en[idx_q] = 1'b1;
  end

  assign busy      = (state_q == SETTLE) || (state_q == MEASURE) || (state_q == REPORT);
  assign res_valid = (state_q == REPORT);
  assign done      = (state_q == FINISH);
  assign res_idx   = res_idx_q;
  assign res_count = res_count_q;
  assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_ro_scan_controller.sv
// Directed bench for ro_scan_controller: free-running modelled ROs, a negedge monitor
// collecting results/enable lengths, and one task per scenario with inline checks.
module tb_ro_scan_controller;

  localparam int NRO = 4;
  localparam int CW  = 4;
  localparam int WW  = 16;
  localparam int SC  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [WW-1:0]   window_len = '0;
  wire  [NRO-1:0]  ro_out;
  logic [NRO-1:0]  ro_en;
  logic            busy;
  logic            res_valid;
  logic [1:0]      res_idx;
  logic [CW-1:0]   res_count;
  logic            res_sat;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;

  ro_scan_controller #(.NUM_RO(NRO), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
    .ro_out(ro_out), .ro_en(ro_en), .busy(busy), .res_valid(res_valid),
    .res_idx(res_idx), .res_count(res_count), .res_sat(res_sat), .done(done)
  );

  always #5 clk = ~clk;

  // RO i toggles every ro_half[i] time units; edges sit at 3 mod 10, clear of clk edges.
  int ro_half [NRO];
  for (genvar g = 0; g < NRO; g++) begin : g_ro
    logic r;
    initial begin
      r = 1'b0;
      #3;
      forever begin
        #(ro_half[g]);
        r = ~r;
      end
    end
    assign ro_out[g] = r;
  end

  int   cyc = 0;
  int   done_cnt, done_cyc, last_res_cyc, onehot_viol;
  logic busy_at_done;
  int   en_run [NRO];
  int   en_len_last [NRO];
  int   r_idx [$];
  int   r_cnt [$];
  int   r_sat [$];

  always @(negedge clk) begin
    if ($countones(ro_en) > 1) onehot_viol++;
    for (int i = 0; i < NRO; i++) begin
      if (ro_en[i]) en_run[i]++;
      else if (en_run[i] != 0) begin
        en_len_last[i] = en_run[i];
        en_run[i] = 0;
      end
    end
    if (res_valid) begin
      r_idx.push_back(int'(res_idx));
      r_cnt.push_back(int'(res_count));
      r_sat.push_back(int'(res_sat));
      last_res_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    cyc++;
  end

  task automatic clear_mon();
    r_idx.delete();
    r_cnt.delete();
    r_sat.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_res_cyc = -100;
    onehot_viol = 0;
    busy_at_done = 1'b1;
    for (int i = 0; i < NRO; i++) begin
      en_run[i] = 0;
      en_len_last[i] = 0;
    end
  endtask

  task automatic set_halves(input int h0, input int h1, input int h2, input int h3);
    ro_half[0] = h0;
    ro_half[1] = h1;
    ro_half[2] = h2;
    ro_half[3] = h3;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit; k++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_errors++;
      $display("FAIL scan_timeout: no done after %0d cycles, required one done pulse", limit);
    end
    repeat (5) @(negedge clk);
  endtask

  // Starts a scan, then scrambles window_len to show the captured value is used.
  task automatic run_scan(input int win, input int limit,
                          output logic b1, output logic [NRO-1:0] e1);
    @(posedge clk); #1;
    window_len = WW'(win);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    window_len = '1;
    @(negedge clk);
    b1 = busy;
    e1 = ro_en;
    wait_done(limit);
  endtask

  task automatic test_reset();
    int bad = 0;
    int bad2 = 0;
    #1 rst_n = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ro_en !== '0 || busy !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL reset_hold: %0d bad cycles, required 0", bad); end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    repeat (50) begin
      @(negedge clk);
      if (ro_en !== '0 || busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) bad2++;
    end
    n_checks++;
    if (bad2 != 0) begin n_errors++; $display("FAIL idle_outputs: %0d bad cycles, required 0", bad2); end
    n_checks++;
    if (res_idx !== 2'd0 || res_count !== 4'd0 || res_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_res: idx=%0d cnt=%0d sat=%0d, required 0/0/0", res_idx, res_count, res_sat);
    end
    n_checks++;
    if (r_idx.size() != 0) begin n_errors++; $display("FAIL idle_no_result: got %0d results, required 0", r_idx.size()); end
  endtask

  task automatic test_basic();
    int exp_cnt [NRO] = '{10, 8, 7, 6};
    logic b1;
    logic [NRO-1:0] e1;
    set_halves(50, 60, 70, 80);
    clear_mon();
    run_scan(100, 2000, b1, e1);
    n_checks++;
    if (b1 !== 1'b1 || e1 !== 4'b0001) begin
      n_errors++;
      $display("FAIL basic_first_cycle: busy=%0b ro_en=%b, required 1/0001", b1, e1);
    end
    n_checks++;
    if (r_idx.size() != NRO) begin n_errors++; $display("FAIL basic_nres: got %0d, required %0d", r_idx.size(), NRO); end
    for (int i = 0; i < r_idx.size() && i < NRO; i++) begin
      n_checks++;
      if (r_idx[i] != i) begin n_errors++; $display("FAIL basic_idx[%0d]: got %0d, required %0d", i, r_idx[i], i); end
      n_checks++;
      if (r_cnt[i] < exp_cnt[i] - 1 || r_cnt[i] > exp_cnt[i] + 1 || r_sat[i] != 0) begin
        n_errors++;
        $display("FAIL basic_count[%0d]: got %0d sat %0d, required %0d+-1 sat 0", i, r_cnt[i], r_sat[i], exp_cnt[i]);
      end
    end
    for (int i = 0; i < NRO; i++) begin
      n_checks++;
      if (en_len_last[i] != SC + 100) begin
        n_errors++;
        $display("FAIL basic_en_len[%0d]: got %0d, required %0d", i, en_len_last[i], SC + 100);
      end
    end
    n_checks++;
    if (onehot_viol != 0) begin n_errors++; $display("FAIL basic_onehot: %0d violations, required 0", onehot_viol); end
    n_checks++;
    if (done_cnt != 1 || done_cyc != last_res_cyc + 1) begin
      n_errors++;
      $display("FAIL basic_done: count %0d at cyc %0d, required 1 at cyc %0d", done_cnt, done_cyc, last_res_cyc + 1);
    end
    n_checks++;
    if (busy_at_done !== 1'b0) begin n_errors++; $display("FAIL basic_busy_done: got %0b, required 0", busy_at_done); end
  endtask

  task automatic test_saturation();
    logic b1;
    logic [NRO-1:0] e1;
    set_halves(20, 500, 500, 500);
    clear_mon();
    run_scan(200, 3000, b1, e1);
    n_checks++;
    if (r_idx.size() != NRO) begin
      n_errors++;
      $display("FAIL sat_nres: got %0d, required %0d", r_idx.size(), NRO);
    end else begin
      n_checks++;
      if (r_cnt[0] != 15 || r_sat[0] != 1) begin
        n_errors++;
        $display("FAIL sat_ro0: got cnt %0d sat %0d, required 15/1", r_cnt[0], r_sat[0]);
      end
      n_checks++;
      if (r_cnt[1] < 1 || r_cnt[1] > 3 || r_sat[1] != 0) begin
        n_errors++;
        $display("FAIL sat_ro1_clear: got cnt %0d sat %0d, required 2+-1/0", r_cnt[1], r_sat[1]);
      end
    end
  endtask

  task automatic test_win_zero();
    logic b1;
    logic [NRO-1:0] e1;
    int bad = 0;
    set_halves(10, 10, 10, 10);
    clear_mon();
    run_scan(0, 500, b1, e1);
    for (int i = 0; i < NRO; i++) if (en_len_last[i] != SC + 1) bad++;
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL win0_en_len: %0d ROs wrong (RO0=%0d), required %0d", bad, en_len_last[0], SC + 1); end
    bad = 0;
    for (int i = 0; i < r_cnt.size(); i++) if (r_cnt[i] > 1) bad++;
    n_checks++;
    if (bad != 0 || r_idx.size() != NRO || done_cnt != 1) begin
      n_errors++;
      $display("FAIL win0_results: %0d over-count, %0d results, %0d done, required 0/%0d/1", bad, r_idx.size(), done_cnt, NRO);
    end
  endtask

  task automatic test_abort();
    logic b1;
    logic [NRO-1:0] e1;
    bit seen = 0;
    set_halves(50, 60, 70, 80);
    clear_mon();
    @(posedge clk); #1;
    window_len = 16'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ro_en === 4'b0100) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL abort_wait: RO2 enable not seen, required within 2000 cycles"); end
    repeat (20) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ro_en !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_stop: ro_en=%b busy=%0b, required 0000/0", ro_en, busy);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (r_idx.size() != 2 || done_cnt != 0 || res_idx !== 2'd1) begin
      n_errors++;
      $display("FAIL abort_results: %0d results, %0d done, res_idx %0d, required 2/0/1", r_idx.size(), done_cnt, res_idx);
    end
    clear_mon();
    run_scan(100, 2000, b1, e1);
    n_checks++;
    if (e1 !== 4'b0001 || r_idx.size() != NRO || done_cnt != 1 || r_idx[0] != 0) begin
      n_errors++;
      $display("FAIL abort_restart: ro_en=%b, %0d results, %0d done, required 0001/%0d/1 from idx 0", e1, r_idx.size(), done_cnt, NRO);
    end
  endtask

  task automatic test_async_reset_busy();
    bit seen = 0;
    set_halves(50, 60, 70, 80);
    clear_mon();
    @(posedge clk); #1;
    window_len = 16'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ro_en === 4'b0001) begin seen = 1; break; end
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!seen || ro_en !== '0 || busy !== 1'b0 || res_idx !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: seen=%0b ro_en=%b busy=%0b res_idx=%0d, required 1/0000/0/0", seen, ro_en, busy, res_idx);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    @(posedge clk); #1;
    window_len = 16'd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
      start = (k == 10 || k == 150 || k == 300);
    end
    start = 1'b0;
    n_checks++;
    if (done_cnt == 0) begin n_errors++; $display("FAIL busy_start_timeout: no done, required one within 2000 cycles"); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (r_idx.size() != NRO || done_cnt != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_start: %0d results, %0d done, busy %0b, required %0d/1/0", r_idx.size(), done_cnt, busy, NRO);
    end
  endtask

  initial begin
    set_halves(50, 60, 70, 80);
    clear_mon();
    test_reset();
    test_basic();
    test_saturation();
    test_win_zero();
    test_abort();
    test_async_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
